// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS control FSM.
// Sequences each instruction over 3-5 cycles for a shared-memory,
// shared-ALU datapath, stalls on MemReady and counts retired instructions.
// Optional build macro CONTROL_ILLEGAL_TRAP_EN: illegal opcodes enter a
// sticky TRAP state and raise the Trap port (the port exists only then).
module multicycle_control #(
  parameter int ALUOP_WIDTH      = 3,
  parameter int USE_MEM_READY    = 1,
  parameter int RETIRE_CNT_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [5:0]                  OP,
  input  logic                        MemReady,
  output logic                        PCWrite,
  output logic                        BranchEQ,
  output logic                        BranchNE,
  output logic                        IorD,
  output logic                        MemRead,
  output logic                        MemWrite,
  output logic                        IRWrite,
  output logic                        MemtoReg,
  output logic                        RegDst,
  output logic                        Link,
  output logic                        RegWrite,
  output logic                        ALUSrcA,
  output logic [1:0]                  ALUSrcB,
  output logic [1:0]                  PCSrc,
  output logic [ALUOP_WIDTH-1:0]      ALUOp,
  output logic [RETIRE_CNT_WIDTH-1:0] InstrCount,
`ifdef CONTROL_ILLEGAL_TRAP_EN
  output logic                        Trap,
`endif
  output logic [3:0]                  State
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t                        state_q, state_d;
  logic [5:0]                    op_q, op_d;
  logic [RETIRE_CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [2:0]                    aluop_code;
  logic                          mem_rdy;
  logic                          retire;

  // With the handshake disabled every memory access completes at once.
  assign mem_rdy = (USE_MEM_READY != 0) ? MemReady : 1'b1;

  // State, latched opcode and retire counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and control outputs; everything is held at 0 while reset is high.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    aluop_code = 3'b000;
    PCWrite    = 1'b0;
    BranchEQ   = 1'b0;
    BranchNE   = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    MemtoReg   = 1'b0;
    RegDst     = 1'b0;
    Link       = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
`ifdef CONTROL_ILLEGAL_TRAP_EN
    Trap       = 1'b0;
`endif
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          // IR and PC load only in the cycle the instruction word arrives.
          IRWrite = mem_rdy;
          PCWrite = mem_rdy;
          if (mem_rdy) state_d = S_DECODE;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          op_d    = OP;
          case (OP)
            OP_RTYPE:                          state_d = S_R_EXEC;
            OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
            OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
            OP_J, OP_JAL:                      state_d = S_JUMP;
            OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:  state_d = S_I_EXEC;
`ifdef CONTROL_ILLEGAL_TRAP_EN
            default:                           state_d = S_TRAP;
`else
            // PC has already advanced, so an unknown opcode acts as a NOP.
            default:                           state_d = S_FETCH;
`endif
          endcase
        end
        S_MEM_ADDR: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
          aluop_code = (op_q == OP_SW) ? 3'b110 : 3'b101;
          state_d    = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
        end
        S_MEM_READ: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          if (mem_rdy) state_d = S_MEM_WB;
        end
        S_MEM_WB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
          state_d  = S_FETCH;
        end
        S_MEM_WRITE: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          if (mem_rdy) state_d = S_FETCH;
        end
        S_R_EXEC: begin
          ALUSrcA    = 1'b1;
          aluop_code = 3'b111;
          state_d    = S_R_WB;
        end
        S_R_WB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
          state_d  = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA    = 1'b1;
          aluop_code = 3'b100;
          PCSrc      = 2'b01;
          BranchEQ   = (op_q == OP_BEQ);
          BranchNE   = (op_q == OP_BNE);
          state_d    = S_FETCH;
        end
        S_JUMP: begin
          PCSrc    = 2'b10;
          PCWrite  = 1'b1;
          Link     = (op_q == OP_JAL);
          RegWrite = (op_q == OP_JAL);
          state_d  = S_FETCH;
        end
        S_I_EXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          case (op_q)
            OP_ANDI: aluop_code = 3'b011;
            OP_ORI:  aluop_code = 3'b001;
            OP_LUI:  aluop_code = 3'b010;
            default: aluop_code = 3'b000;
          endcase
          state_d = S_I_WB;
        end
        S_I_WB: begin
          RegWrite = 1'b1;
          state_d  = S_FETCH;
        end
`ifdef CONTROL_ILLEGAL_TRAP_EN
        S_TRAP: begin
          Trap    = 1'b1;
          state_d = S_TRAP;
        end
`endif
        default: state_d = S_FETCH;
      endcase
    end
  end

  // An instruction retires on its return to FETCH; DECODE->FETCH is an illegal-opcode NOP.
  always_comb begin
    retire = (state_q != S_FETCH) && (state_q != S_DECODE) && (state_d == S_FETCH);
    cnt_d  = cnt_q + RETIRE_CNT_WIDTH'(retire);
  end

  assign ALUOp      = ALUOP_WIDTH'(aluop_code);
  assign InstrCount = cnt_q;
  assign State      = state_q;

endmodule
